// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: shared sizing and the queue entry type for the instruction queue.
package instruction_queue_pkg;
  localparam int BW_PROCESSOR_DATA = 32;
  localparam int BW_PROCESSOR_BLOCK = 64;
  localparam int BW_ADDRESS = 32;
  localparam int NUM_GLOBAL_HISTORY = 4;
  localparam int NUM_IQ_ENTRY = 8;
  localparam int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA;
  localparam int BW_PC_MOD = $clog2(NUM_FIFO_INPUT_ENTRY) + int'(NUM_FIFO_INPUT_ENTRY <= 1);
  localparam int BW_IQ_PTR = $clog2(NUM_IQ_ENTRY);
  localparam int BW_IQ_CNT = BW_IQ_PTR + 1;
  localparam int BW_PUSH_CNT = $clog2(NUM_FIFO_INPUT_ENTRY + 1);
  typedef struct packed {
    logic [BW_PROCESSOR_DATA-1:0] instruction;
    logic [BW_ADDRESS-1:0] pc;
    logic [BW_ADDRESS-1:0] pc_next;
    logic [NUM_GLOBAL_HISTORY-1:0] global_history;
  } iq_entry_t;
endpackage

// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch-side and issue-side handshakes of the instruction queue.
interface instruction_queue_if;
  import instruction_queue_pkg::*;
  logic i_branch_valid;
  logic i_branch_correct_prediction;
  logic i_pc_valid;
  logic i_pc_ready;
  logic [BW_PROCESSOR_BLOCK-1:0] i_pc_instruction_flatten;
  logic [BW_ADDRESS-1:0] i_pc;
  logic [BW_PC_MOD-1:0] i_pc_upperbound;
  logic [BW_PROCESSOR_BLOCK-1:0] i_pc_next_flatten;
  logic [NUM_GLOBAL_HISTORY-1:0] i_global_history;
  logic o_issue_valid;
  logic o_issue_ready;
  logic [BW_PROCESSOR_DATA-1:0] o_issue_instruction;
  logic [BW_ADDRESS-1:0] o_issue_pc;
  logic [BW_ADDRESS-1:0] o_issue_pc_next;
  logic [NUM_GLOBAL_HISTORY-1:0] o_issue_global_history;
  modport slave (
    input i_branch_valid, i_branch_correct_prediction, i_pc_valid, i_pc_instruction_flatten,
    i_pc, i_pc_upperbound, i_pc_next_flatten, i_global_history, o_issue_ready,
    output i_pc_ready, o_issue_valid, o_issue_instruction, o_issue_pc, o_issue_pc_next,
    o_issue_global_history
  );
  modport master (
    output i_branch_valid, i_branch_correct_prediction, i_pc_valid, i_pc_instruction_flatten,
    i_pc, i_pc_upperbound, i_pc_next_flatten, i_global_history, o_issue_ready,
    input i_pc_ready, o_issue_valid, o_issue_instruction, o_issue_pc, o_issue_pc_next,
    o_issue_global_history
  );
endinterface

// File: rtl/instruction_queue_iq_ring_buffer.sv
// iq_ring_buffer: circular entry store with multi-entry write, single read and flush.
module iq_ring_buffer
  import instruction_queue_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic pop_i,
  input  logic [BW_PUSH_CNT-1:0] push_cnt_i,
  input  iq_entry_t [NUM_FIFO_INPUT_ENTRY-1:0] wr_data_i,
  output iq_entry_t rd_data_o,
  output logic [BW_IQ_CNT-1:0] count_o
);
  iq_entry_t mem_q [NUM_IQ_ENTRY];
  logic [BW_IQ_PTR-1:0] head_q, head_d, tail_q, tail_d;
  logic [BW_IQ_CNT-1:0] count_q, count_d;
  always_comb begin
    head_d = flush_i ? '0 : head_q + BW_IQ_PTR'(pop_i);
    tail_d = flush_i ? '0 : tail_q + BW_IQ_PTR'(push_cnt_i);
    count_d = flush_i ? '0 : count_q + BW_IQ_CNT'(push_cnt_i) - BW_IQ_CNT'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_IQ_ENTRY; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      for (int j = 0; j < NUM_FIFO_INPUT_ENTRY; j++)
        if (!flush_i && BW_PUSH_CNT'(j) < push_cnt_i) mem_q[tail_q + BW_IQ_PTR'(j)] <= wr_data_i[j];
    end
  end
  assign rd_data_o = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: unpacks fetch blocks into per-instruction entries and issues them in order.
module instruction_queue
  import instruction_queue_pkg::*;
(
  input logic clk,
  input logic rst_n,
  instruction_queue_if.slave bus
);
  logic flush, push, pop;
  logic [BW_IQ_CNT-1:0] count;
  logic [BW_PC_MOD-1:0] start;
  logic [BW_ADDRESS-1:0] base;
  logic [BW_PUSH_CNT-1:0] n_push, push_cnt;
  logic [NUM_FIFO_INPUT_ENTRY-1:0][BW_PROCESSOR_DATA-1:0] instr;
  logic [NUM_FIFO_INPUT_ENTRY-1:0][BW_ADDRESS-1:0] pc_next;
  iq_entry_t [NUM_FIFO_INPUT_ENTRY-1:0] wr_data;
  iq_entry_t rd_data;
  assign instr = bus.i_pc_instruction_flatten;
  assign pc_next = bus.i_pc_next_flatten;
  assign flush = bus.i_branch_valid && !bus.i_branch_correct_prediction;
  assign bus.i_pc_ready = count <= BW_IQ_CNT'(NUM_IQ_ENTRY - NUM_FIFO_INPUT_ENTRY);
  assign push = bus.i_pc_valid && bus.i_pc_ready && !flush;
  assign bus.o_issue_valid = count != '0;
  assign pop = bus.o_issue_valid && bus.o_issue_ready;
  assign start = bus.i_pc[BW_PC_MOD+1:2];
  assign base = bus.i_pc & ~BW_ADDRESS'((1 << (BW_PC_MOD + 2)) - 1);
  assign n_push = start > bus.i_pc_upperbound ? '0
                : BW_PUSH_CNT'(bus.i_pc_upperbound - start) + BW_PUSH_CNT'(1);
  assign push_cnt = push ? n_push : '0;
  // Compact slots start..upperbound to the low write lanes; lanes past n_push are ignored.
  for (genvar j = 0; j < NUM_FIFO_INPUT_ENTRY; j++) begin : g_lane
    logic [BW_PC_MOD-1:0] s;
    assign s = start + BW_PC_MOD'(j);
    assign wr_data[j] = '{instruction: instr[s], pc: base + BW_ADDRESS'({s, 2'b00}),
                          pc_next: pc_next[s], global_history: bus.i_global_history};
  end
  iq_ring_buffer u_ring (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush),
    .pop_i(pop),
    .push_cnt_i(push_cnt),
    .wr_data_i(wr_data),
    .rd_data_o(rd_data),
    .count_o(count)
  );
  assign bus.o_issue_instruction = rd_data.instruction;
  assign bus.o_issue_pc = rd_data.pc;
  assign bus.o_issue_pc_next = rd_data.pc_next;
  assign bus.o_issue_global_history = rd_data.global_history;
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: vector table, corner sequences and random traffic against a queue model.
module tb_instruction_queue;
  import instruction_queue_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  iq_entry_t mq[$];
  instruction_queue_if bus();
  instruction_queue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [31:0] pc; logic ub;
    logic [31:0] i0, i1, n0, n1; logic [3:0] gh;
    logic rdy, bv, bc;
    logic ev; logic [31:0] ei, ep, en;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_blk(logic v, logic [31:0] pc, logic ub, logic [31:0] i0, logic [31:0] i1,
                         logic [31:0] n0, logic [31:0] n1, logic [3:0] gh);
    bus.i_pc_valid = v;
    bus.i_pc = pc;
    bus.i_pc_upperbound = ub;
    bus.i_pc_instruction_flatten = {i1, i0};
    bus.i_pc_next_flatten = {n1, n0};
    bus.i_global_history = gh;
  endtask

  task automatic blk(logic [31:0] pc, logic ub);
    set_blk(1'b1, pc, ub, pc | 32'hA000_0000, pc | 32'hB000_0000, pc + 32'h40, pc + 32'h80, pc[6:3]);
  endtask

  // One cycle: check outputs against the model, clock, then apply the queue rules to the model.
  task automatic step();
    bit exp_v, exp_r, flush, push, pop;
    iq_entry_t e;
    int start, ub;
    #1;
    exp_v = mq.size() != 0;
    exp_r = (NUM_IQ_ENTRY - mq.size()) >= NUM_FIFO_INPUT_ENTRY;
    chk("issue_valid", 32'(bus.o_issue_valid), 32'(exp_v));
    chk("pc_ready", 32'(bus.i_pc_ready), 32'(exp_r));
    if (exp_v) begin
      chk("issue_instr", bus.o_issue_instruction, mq[0].instruction);
      chk("issue_pc", bus.o_issue_pc, mq[0].pc);
      chk("issue_pc_next", bus.o_issue_pc_next, mq[0].pc_next);
      chk("issue_gh", 32'(bus.o_issue_global_history), 32'(mq[0].global_history));
    end
    flush = bus.i_branch_valid && !bus.i_branch_correct_prediction;
    push = bus.i_pc_valid && exp_r && !flush;
    pop = exp_v && bus.o_issue_ready;
    start = int'(bus.i_pc[2]);
    ub = int'(bus.i_pc_upperbound);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push)
        for (int s = start; s <= ub; s++) begin
          e.instruction = bus.i_pc_instruction_flatten[32*s +: 32];
          e.pc = (bus.i_pc & 32'hFFFF_FFF8) + 32'(4 * s);
          e.pc_next = bus.i_pc_next_flatten[32*s +: 32];
          e.global_history = bus.i_global_history;
          mq.push_back(e);
        end
    end
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h0, 1'b1, 32'h00A00093, 32'h00100113, 32'h4, 32'h8, 4'h1, 1'b1, 1'b0, 1'b0,
               1'b1, 32'h00A00093, 32'h0, 32'h4};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0,
               1'b1, 32'h00100113, 32'h4, 32'h8};
    tbl[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0,
               1'b0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b1, 32'h4, 1'b1, 32'h22222222, 32'h11111111, 32'h10, 32'h20, 4'h5, 1'b0, 1'b0, 1'b0,
               1'b1, 32'h11111111, 32'h4, 32'h20};
    tbl[4] = '{1'b1, 32'h8, 1'b0, 32'h33333333, 32'h44444444, 32'h40, 32'h0, 4'h3, 1'b0, 1'b0, 1'b0,
               1'b1, 32'h11111111, 32'h4, 32'h20};
    tbl[5] = '{1'b1, 32'hC, 1'b0, 32'h55555555, 32'h66666666, 32'h50, 32'h60, 4'h7, 1'b1, 1'b0, 1'b0,
               1'b1, 32'h33333333, 32'h8, 32'h40};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1,
               1'b0, 32'h0, 32'h0, 32'h0};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0,
               1'b0, 32'h0, 32'h0, 32'h0};
    set_blk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    bus.o_issue_ready = 1'b0;
    bus.i_branch_valid = 1'b0;
    bus.i_branch_correct_prediction = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.o_issue_valid), 32'h0);
    chk("rst_ready", 32'(bus.i_pc_ready), 32'h1);
    chk("rst_instr", bus.o_issue_instruction, 32'h0);
    chk("rst_pc", bus.o_issue_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_blk(tbl[i].v, tbl[i].pc, tbl[i].ub, tbl[i].i0, tbl[i].i1, tbl[i].n0, tbl[i].n1, tbl[i].gh);
      bus.o_issue_ready = tbl[i].rdy;
      bus.i_branch_valid = tbl[i].bv;
      bus.i_branch_correct_prediction = tbl[i].bc;
      step();
      chk("tbl_valid", 32'(bus.o_issue_valid), 32'(tbl[i].ev));
      chk("tbl_pc_ready", 32'(bus.i_pc_ready), 32'h1);
      if (tbl[i].ev) begin
        chk("tbl_instr", bus.o_issue_instruction, tbl[i].ei);
        chk("tbl_pc", bus.o_issue_pc, tbl[i].ep);
        chk("tbl_pc_next", bus.o_issue_pc_next, tbl[i].en);
      end
    end
    bus.i_branch_valid = 1'b0;
    bus.i_branch_correct_prediction = 1'b0;
    // Fill to full across the pointer wrap, then drain one at a time.
    bus.o_issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      blk(32'h100 + 32'(8 * k), 1'b1);
      step();
      chk("fill_ready", 32'(bus.i_pc_ready), 32'(k < 3));
    end
    bus.i_pc_valid = 1'b0;
    bus.o_issue_ready = 1'b1;
    step();
    chk("count7_ready", 32'(bus.i_pc_ready), 32'h0);
    step();
    chk("count6_ready", 32'(bus.i_pc_ready), 32'h1);
    chk("wrap_head_pc", bus.o_issue_pc, 32'h108);
    repeat (6) step();
    chk("drained_valid", 32'(bus.o_issue_valid), 32'h0);
    // Mispredict in the same cycle as a push and a pop.
    bus.o_issue_ready = 1'b0;
    blk(32'h200, 1'b1); step();
    blk(32'h208, 1'b1); step();
    blk(32'h210, 1'b0); step();
    blk(32'h300, 1'b1);
    bus.o_issue_ready = 1'b1;
    bus.i_branch_valid = 1'b1;
    step();
    bus.i_branch_valid = 1'b0;
    chk("flush_valid", 32'(bus.o_issue_valid), 32'h0);
    chk("flush_ready", 32'(bus.i_pc_ready), 32'h1);
    bus.o_issue_ready = 1'b0;
    blk(32'h400, 1'b1); step();
    chk("post_flush_valid", 32'(bus.o_issue_valid), 32'h1);
    chk("post_flush_pc", bus.o_issue_pc, 32'h400);
    blk(32'h408, 1'b1); step();
    blk(32'h410, 1'b1); step();
    chk("count6_ready_b", 32'(bus.i_pc_ready), 32'h1);
    blk(32'h418, 1'b1);
    bus.o_issue_ready = 1'b1;
    step();
    chk("push_pop_ready", 32'(bus.i_pc_ready), 32'h0);
    chk("push_pop_head", bus.o_issue_pc, 32'h404);
    bus.i_pc_valid = 1'b0;
    bus.o_issue_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.o_issue_valid), 32'h0);
    chk("async_rst_ready", 32'(bus.i_pc_ready), 32'h1);
    chk("async_rst_instr", bus.o_issue_instruction, 32'h0);
    mq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1500) begin
      set_blk(1'($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom, $urandom, 4'($urandom));
      bus.o_issue_ready = 1'($urandom_range(0, 9) < 6);
      bus.i_branch_valid = 1'($urandom_range(0, 19) == 0);
      bus.i_branch_correct_prediction = 1'($urandom_range(0, 1));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Consumer end of the fetch-to-instruction-queue two-wire handshake.
- Each accepted fetch block holds NUM_FIFO_INPUT_ENTRY instruction slots. The block is unpacked into individual entries, each carrying its instruction, its PC, its predicted next PC and the global branch history.
- Entries are buffered in a circular queue and issued one per cycle to decode/issue over a second valid/ready handshake.
- A branch mispredict flushes the whole queue.

Parameters:
- BW_PROCESSOR_DATA, 32, instruction width; must equal BW_ADDRESS.
- BW_PROCESSOR_BLOCK, 64, fetch block width.
- BW_ADDRESS, 32, PC width.
- NUM_GLOBAL_HISTORY, 4, global history width.
- NUM_IQ_ENTRY, 8, queue depth; power of two, at least NUM_FIFO_INPUT_ENTRY.
- NUM_FIFO_INPUT_ENTRY, BW_PROCESSOR_BLOCK/BW_PROCESSOR_DATA, slots per block.
- BW_PC_MOD, $clog2(NUM_FIFO_INPUT_ENTRY)+(NUM_FIFO_INPUT_ENTRY<=1), slot index width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_branch_valid  input  1  branch resolution strobe.
- i_branch_correct_prediction  input  1  resolved branch was predicted correctly.
- i_pc_valid  input  1  fetch block valid.
- i_pc_ready  output  1  queue can accept a block.
- i_pc_instruction_flatten  input  BW_PROCESSOR_BLOCK  slot i at bits [i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA].
- i_pc  input  BW_ADDRESS  PC of the first valid instruction in the block.
- i_pc_upperbound  input  BW_PC_MOD  last valid slot, inclusive.
- i_pc_next_flatten  input  BW_PROCESSOR_BLOCK  predicted next PC for each slot.
- i_global_history  input  NUM_GLOBAL_HISTORY  history shared by the block.
- o_issue_valid  output  1  head entry valid.
- o_issue_ready  input  1  issue accepts the head entry.
- o_issue_instruction  output  BW_PROCESSOR_DATA  head instruction.
- o_issue_pc  output  BW_ADDRESS  head PC.
- o_issue_pc_next  output  BW_ADDRESS  head predicted next PC.
- o_issue_global_history  output  NUM_GLOBAL_HISTORY  head history.

Behaviour:
- Reset (async, may occur mid-operation): head, tail and count = 0; all entry storage = 0.
  - o_issue_valid = 0; all o_issue_* data = 0.
  - i_pc_ready = 1, since the queue is empty.
- Signal definitions:
  - flush = i_branch_valid && !i_branch_correct_prediction.
  - push = i_pc_valid && i_pc_ready && !flush.
  - pop = o_issue_valid && o_issue_ready.
- i_pc_ready is combinational: (NUM_IQ_ENTRY - count) >= NUM_FIFO_INPUT_ENTRY.
  - Based on the registered count only; no credit is given for a same-cycle pop.
  - Independent of i_pc_valid.
- Unpacking on push:
  - start = i_pc[BW_PC_MOD+1:2]; base = i_pc with bits [BW_PC_MOD+1:0] cleared.
  - Slots start..i_pc_upperbound are written in ascending order at tail, tail+1, and so on.
  - Entry k stores slot instruction k, PC base + 4*k, next PC slot k, and i_global_history.
  - n_push = upperbound - start + 1.
  - If start > upperbound, n_push = 0: the handshake completes and nothing is written.
- Issue:
  - o_issue_valid = (count != 0) and is driven from registered state only.
  - o_issue_* reflect the entry at head; they are stable while valid && !ready.
  - Latency: an entry pushed at edge N is issuable in the cycle after edge N. There is no input-to-output bypass.
  - At most one entry issues per cycle.
- Pointer update:
  - head and tail are log2(NUM_IQ_ENTRY) bits and wrap modulo NUM_IQ_ENTRY.
  - count has log2(NUM_IQ_ENTRY)+1 bits; count_next = count + n_push - pop.
  - Simultaneous push and pop are both honoured.
- Flush takes priority over everything:
  - head, tail and count = 0 at the next edge.
  - The same-cycle input block is discarded even if valid && ready were both high.
  - A same-cycle pop is treated as performed by the consumer; the queue still ends empty.
  - Entry storage is not cleared.
- i_branch_valid with correct prediction has no effect.

Decomposition:
- Shared package holds:
  - NUM_FIFO_INPUT_ENTRY and BW_PC_MOD derivations;
  - typedef iq_entry_t {instruction, pc, pc_next, global_history}.
- One sub-module, iq_ring_buffer, owns storage, the head/tail/count pointers and flush.
  - Write side: a multi-write port of up to NUM_FIFO_INPUT_ENTRY entries plus a count.
  - Read side: a single read port.
- The top level performs block unpacking, start/upperbound decode and handshake generation.

Test Plan:
1. After reset, push i_pc=0x0, slots {0x00A00093, 0x00100113}, upperbound=1, next={0x4, 0x8}, ready held 1 -> next cycle issue (0x00A00093, pc 0x0, next 0x4); following cycle (0x00100113, pc 0x4, next 0x8); then o_issue_valid=0.
2. Push i_pc=0x4, upperbound=1 -> exactly one entry: instruction = bits [63:32], pc 0x4; count 1.
3. Push i_pc=0x8, upperbound=0, next={0x40, x} -> one entry, pc 0x8, next 0x40. Then push i_pc=0xC, upperbound=0 -> handshake completes, count unchanged.
4. o_issue_ready=0, push four 2-slot blocks -> i_pc_ready stays 1 through count 6, drops at count 8. One pop -> count 7, i_pc_ready still 0. Second pop -> count 6, i_pc_ready=1. Issue order preserved across pointer wrap.
5. count=5, push valid&&ready plus i_branch_valid=1, correct=0 in the same cycle -> next cycle count=0, o_issue_valid=0; the pushed block never issues. Next push starts at the new PC.
6. count=6: push 2 slots and pop in the same cycle -> count=7, the correct head advanced. Also assert rst_n low mid-stream -> o_issue_valid=0 immediately, i_pc_ready=1.
